// File: rtl/run_sequencer.sv
// run_sequencer
//   Run controller for the X9 core. Boots, runs and stops one program per
//   host request, owns the core reset, and arbitrates the single data-memory
//   port between the host (IDLE/FINISH) and the core (RUN). Counts RUN
//   cycles and aborts runaway programs with a watchdog.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   req / ack                   host run request (level) / run finished, held until req low
//   timeout                     last run ended by the watchdog
//   cycles                      RUN-cycle count of the current/last run
//   host_gnt                    host owns the memory port
//   host_we/addr/wdat/rdat      host side of the memory port
//   core_done                   core's done flag
//   core_reset                  active-high reset to the core
//   core_we/addr/wdat/rdat      core side of the memory port
//   mem_we/addr/wdat/rdat       to/from dat_mem (combinational read)
module run_sequencer #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TW      = 16,
    parameter int unsigned TMO     = 4096,
    parameter int unsigned RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic          timeout,
    output logic [TW-1:0] cycles,
    output logic          host_gnt,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic [DW-1:0] host_rdat,
    input  logic          core_done,
    output logic          core_reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic [DW-1:0] core_rdat,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
);

    localparam int unsigned BW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOOT   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   boot_q;
    logic [TW-1:0]   cycles_q;
    logic            timeout_q;

    logic            boot_last;
    logic            wdog_hit;

    assign boot_last = (boot_q == BW'(RST_CYC - 1));
    assign wdog_hit  = (cycles_q == TW'(TMO - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req)       state_d = BOOT;
            BOOT:    if (boot_last) state_d = RUN;
            RUN:     if (core_done || wdog_hit) state_d = FINISH;
            FINISH:  if (!req)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Boot hold counter, run-cycle counter and watchdog flag.
    // The counter is cleared on acceptance, so the final count survives FINISH
    // and the following IDLE for the host to read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            boot_q    <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    boot_q <= '0;
                    if (req) begin
                        cycles_q  <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                BOOT: begin
                    if (!boot_last) begin
                        boot_q <= boot_q + BW'(1);
                    end
                end
                RUN: begin
                    cycles_q <= cycles_q + TW'(1);
                    // core_done takes precedence over the watchdog
                    if (!core_done && wdog_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack        = (state_q == FINISH);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;
    assign host_gnt   = (state_q == IDLE) || (state_q == FINISH);
    assign core_reset = (state_q != RUN);

    // Memory port mux, decoded from the registered state only
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdat  = '0;
        host_rdat = '0;
        core_rdat = '0;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdat  = host_wdat;
            host_rdat = mem_rdat;
        end else if (state_q == RUN) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdat  = core_wdat;
            core_rdat = mem_rdat;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned TW  = 16;
    localparam int unsigned TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          ack;
    logic          timeout;
    logic [TW-1:0] cycles;
    logic          host_gnt;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdat;
    logic [DW-1:0] host_rdat;
    logic          core_done;
    logic          core_reset;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdat;
    logic [DW-1:0] core_rdat;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [DW-1:0] dmem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // dat_mem stand-in: clocked write, combinational read
    always_ff @(posedge clk) begin
        if (mem_we) dmem[mem_addr] <= mem_wdat;
    end
    assign mem_rdat = dmem[mem_addr];

    run_sequencer #(
        .AW(AW), .DW(DW), .TW(TW), .TMO(TMO), .RST_CYC(2)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .timeout(timeout),
        .cycles(cycles), .host_gnt(host_gnt), .host_we(host_we),
        .host_addr(host_addr), .host_wdat(host_wdat), .host_rdat(host_rdat),
        .core_done(core_done), .core_reset(core_reset), .core_we(core_we),
        .core_addr(core_addr), .core_wdat(core_wdat), .core_rdat(core_rdat),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_run();
        req = 1'b1;
        tick();
        check("boot1_core_reset", 32'(core_reset), 1);
        check("boot1_host_gnt", 32'(host_gnt), 0);
        check("boot_cleared_cycles", 32'(cycles), 0);
        check("boot_cleared_timeout", 32'(timeout), 0);
        tick();
        check("boot2_core_reset", 32'(core_reset), 1);
        tick();
        check("run_core_reset", 32'(core_reset), 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) dmem[i] = '0;
        reset = 1'b0; req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdat = '0;
        core_done = 1'b0; core_we = 1'b0; core_addr = '0; core_wdat = '0;
        #1;
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_host_gnt", 32'(host_gnt), 1);
        check("rst_ack", 32'(ack), 0);
        check("rst_cycles", 32'(cycles), 0);
        tick();
        reset = 1'b1;
        tick();

        // Host write in the accepting cycle, then a 37-cycle run
        host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'hA5; req = 1'b1;
        #1;
        check("accept_mem_we", 32'(mem_we), 1);
        tick();
        check("boot_mem_we_blocked", 32'(mem_we), 0);
        check("boot_host_rdat", 32'(host_rdat), 0);
        check("boot_core_rdat", 32'(core_rdat), 0);
        host_we = 1'b0;
        tick();
        check("boot2_core_reset", 32'(core_reset), 1);
        tick();
        check("run1_core_reset", 32'(core_reset), 0);
        check("run1_host_gnt", 32'(host_gnt), 0);
        check("run1_cycles", 32'(cycles), 0);
        req = 1'b0;   // dropping req mid-run is ignored
        host_we = 1'b1; host_addr = 8'h20; host_wdat = 8'h3C;
        core_we = 1'b0; core_addr = 8'h10;
        #1;
        check("run_host_we_dropped", 32'(mem_we), 0);
        check("run_host_rdat_zero", 32'(host_rdat), 0);
        check("run_core_rdat", 32'(core_rdat), 32'hA5);
        check("run_mem_addr_core", 32'(mem_addr), 32'h10);
        core_we = 1'b1; core_addr = 8'h30; core_wdat = 8'h77;
        #1;
        check("run_mem_we_core", 32'(mem_we), 1);
        check("run_mem_wdat_core", 32'(mem_wdat), 32'h77);
        tick();
        check("run2_cycles", 32'(cycles), 1);
        core_we = 1'b0; host_we = 1'b0;
        req = 1'b1;
        repeat (35) tick();
        check("run37_cycles", 32'(cycles), 36);
        check("run37_ack", 32'(ack), 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("t2_ack", 32'(ack), 1);
        check("t2_cycles", 32'(cycles), 37);
        check("t2_timeout", 32'(timeout), 0);
        check("fin_core_reset", 32'(core_reset), 1);
        check("fin_host_gnt", 32'(host_gnt), 1);
        host_addr = 8'h10; #1;
        check("read_10", 32'(host_rdat), 32'hA5);
        check("fin_core_rdat", 32'(core_rdat), 0);
        host_addr = 8'h20; #1;
        check("read_20_unchanged", 32'(host_rdat), 0);
        host_addr = 8'h30; #1;
        check("read_30_core", 32'(host_rdat), 32'h77);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fin_hold_ack", 32'(ack), 1);
        end
        req = 1'b0;
        tick();
        check("idle_ack_low", 32'(ack), 0);
        check("idle_cycles_kept", 32'(cycles), 37);
        tick();

        // Watchdog: no done for TMO cycles
        enter_run();
        repeat (TMO - 1) tick();
        check("wd_pre_ack", 32'(ack), 0);
        check("wd_pre_cycles", 32'(cycles), TMO - 1);
        tick();
        check("wd_ack", 32'(ack), 1);
        check("wd_timeout", 32'(timeout), 1);
        check("wd_cycles", 32'(cycles), TMO);
        req = 1'b0;
        tick();

        // Done on RUN cycle TMO beats the watchdog
        enter_run();
        repeat (TMO - 1) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("tie_ack", 32'(ack), 1);
        check("tie_timeout", 32'(timeout), 0);
        check("tie_cycles", 32'(cycles), TMO);
        req = 1'b0;
        tick();
        check("tie_idle_ack", 32'(ack), 0);

        // One-cycle req pulse, done in the first RUN cycle
        req = 1'b1;
        tick();
        req = 1'b0;
        check("pulse_boot", 32'(host_gnt), 0);
        tick();
        tick();
        check("pulse_run", 32'(core_reset), 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("pulse_ack", 32'(ack), 1);
        check("pulse_cycles", 32'(cycles), 1);
        tick();
        check("pulse_idle", 32'(ack), 0);

        // Asynchronous reset mid-RUN
        enter_run();
        repeat (5) tick();
        check("mid_cycles", 32'(cycles), 5);
        #2 reset = 1'b0;
        #1;
        check("async_core_reset", 32'(core_reset), 1);
        check("async_host_gnt", 32'(host_gnt), 1);
        check("async_ack", 32'(ack), 0);
        check("async_cycles", 32'(cycles), 0);
        check("async_timeout", 32'(timeout), 0);
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
